// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned PC_STEP  = 4;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   // RUN: nothing in flight; WAIT: good request in flight; DROP: wrong-path request in flight
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch stage and memory.
interface fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) ();

   logic            req_valid;
   logic [XLEN-1:0] req_addr;
   logic            req_ready;
   logic            resp_valid;
   logic [XLEN-1:0] resp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  resp_valid,
      input  resp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output resp_valid,
      output resp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO kept compacted so the head is always entry 0 (a plain register).
// Unused entries are held at zero, so the head reads zero when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 2 * XLEN_DEF,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] ent_q, ent_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        do_pop, do_push;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still take a push
   assign do_push = push & (~full | do_pop);

   assign head  = ent_q[0];
   assign count = cnt_q;

   // Next entries: flush clears everything, otherwise shift on pop then append on push
   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      if (flush) begin
         ent_d = '0;
         cnt_d = '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               ent_d[i] = ent_q[i+1];
            end
            ent_d[DEPTH-1] = '0;
            cnt_d          = cnt_d - CNT_W'(1);
         end
         if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) == cnt_d) begin
                  ent_d[i] = push_data;
               end
            end
            cnt_d = cnt_d + CNT_W'(1);
         end
      end
   end

   // Entry and count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// buffers returned words with their PC+4 and discards wrong-path data on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN       = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_unit_if.master    imem,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            fd_valid,
   output logic [XLEN-1:0] fd_instruction,
   output logic [XLEN-1:0] fd_pc4
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   req_addr_q, req_addr_d;
   logic              issue, push, pop, space_ok, in_flight;
   logic              fifo_empty, fifo_full;
   logic [CNT_W-1:0]  fifo_count;
   logic [2*XLEN-1:0] fifo_head;
   logic              unused_redirect_bits;

   assign unused_redirect_bits = ^redirect_pc[1:0];

   assign fd_valid       = ~fifo_empty;
   assign fd_instruction = fifo_head[2*XLEN-1:XLEN];
   assign fd_pc4         = fifo_head[XLEN-1:0];
   assign pop            = fd_valid & ~stall;
   assign in_flight      = (state_q != RUN);

   // Credit check: entries held plus requests in flight must leave room for one more.
   // A pop this cycle returns a credit immediately.
   assign space_ok = pop | (~fifo_full &
                            ((32'(fifo_count) + 32'(in_flight)) < FIFO_DEPTH));

   // Held low during reset so nothing is requested before the first active edge
   assign imem.req_valid = issue & rst_n;
   assign imem.req_addr  = pc_q;

   // Next-state, PC update and issue/push decisions; redirect overrides everything
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      issue      = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         RUN: begin
            issue = space_ok & ~redirect_valid;
            if (issue && imem.req_ready) begin
               req_addr_d = pc_q;
               pc_d       = pc_q + XLEN'(PC_STEP);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (imem.resp_valid) begin
               push    = 1'b1;
               state_d = RUN;
            end
         end
         DROP: begin
            if (imem.resp_valid) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (redirect_valid) begin
         push = 1'b0;
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         // An in-flight good request becomes wrong-path unless it lands right now
         if (state_q == WAIT && !imem.resp_valid) begin
            state_d = DROP;
         end
      end
   end

   // State, PC and in-flight address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({imem.resp_data, req_addr_q + XLEN'(PC_STEP)}),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run checked against
// a program-order model (expected PC stream plus a word-per-address memory function).
module tb_fetch_unit;

   localparam int unsigned XLEN = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        fd_valid;
   logic [31:0] fd_instruction;
   logic [31:0] fd_pc4;

   fetch_unit_if #(.XLEN(XLEN)) imem ();

   fetch_unit #(
      .XLEN       (XLEN),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .fd_valid       (fd_valid),
      .fd_instruction (fd_instruction),
      .fd_pc4         (fd_pc4)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Memory model: one pending request, answered mem_lat cycles after acceptance
   bit          mem_pend;
   logic [31:0] mem_addr;
   int          mem_due;
   int          mem_lat;

   // Values observed just before the closing edge of the last simulated cycle
   logic        o_req_valid, o_fd_valid, o_pend;
   logic [31:0] o_req_addr, o_fd_instr, o_fd_pc4;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // One clock cycle: drive inputs, sample outputs, model memory acceptance, cross the edge
   task automatic tick(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem.req_ready = rdy;
      o_pend         = mem_pend;
      if (mem_pend && cyc == mem_due) begin
         imem.resp_valid = 1'b1;
         imem.resp_data  = mem_fn(mem_addr);
         mem_pend        = 1'b0;
      end else begin
         imem.resp_valid = 1'b0;
         imem.resp_data  = $urandom;
      end
      #1;
      o_req_valid = imem.req_valid;
      o_req_addr  = imem.req_addr;
      o_fd_valid  = fd_valid;
      o_fd_instr  = fd_instruction;
      o_fd_pc4    = fd_pc4;
      if (o_req_valid && rdy) begin
         mem_pend = 1'b1;
         mem_addr = o_req_addr;
         mem_due  = cyc + mem_lat;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem.req_ready  = 1'b0;
      imem.resp_valid = 1'b0;
      imem.resp_data  = '0;
      mem_pend        = 1'b0;
      mem_lat         = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      logic        st, rv, rdy;
      logic [31:0] rpc, exp_next, prev_addr, prev_pc4, prev_instr;
      logic        prev_rv, prev_hold, prev_fd_hold;
      int          consumed;

      // Reset values
      rst_n           = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem.req_ready  = 1'b1;
      imem.resp_valid = 1'b0;
      imem.resp_data  = '0;
      #2;
      check("rst_req_valid", 32'(imem.req_valid), 0);
      check("rst_fd_valid", 32'(fd_valid), 0);
      check("rst_fd_instr", fd_instruction, 0);
      check("rst_fd_pc4", fd_pc4, 0);

      // Streaming with k=1, ready=1, no stall
      do_reset();
      tick(0, 0, 0, 1);
      check("s_req0_valid", 32'(o_req_valid), 1);
      check("s_req0_addr", o_req_addr, 32'h0);
      tick(0, 0, 0, 1);
      check("s_wait_no_req", 32'(o_req_valid), 0);
      check("s_wait_fd_valid", 32'(o_fd_valid), 0);
      tick(0, 0, 0, 1);
      check("s_fd0_valid", 32'(o_fd_valid), 1);
      check("s_fd0_instr", o_fd_instr, mem_fn(32'h0));
      check("s_fd0_pc4", o_fd_pc4, 32'h4);
      check("s_req1_addr", o_req_addr, 32'h4);
      tick(0, 0, 0, 1);
      check("s_fd_gap", 32'(o_fd_valid), 0);
      tick(0, 0, 0, 1);
      check("s_fd1_pc4", o_fd_pc4, 32'h8);
      check("s_req2_addr", o_req_addr, 32'h8);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("s_fd2_pc4", o_fd_pc4, 32'hC);
      check("s_fd2_instr", o_fd_instr, mem_fn(32'h8));

      // Long stall fills the FIFO, then drains in order
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(1, 0, 0, 1);
         if (i >= 2) check("st_hold_pc4", o_fd_pc4, 32'h4);
      end
      check("st_full_valid", 32'(o_fd_valid), 1);
      check("st_full_instr", o_fd_instr, mem_fn(32'h0));
      check("st_full_no_req", 32'(o_req_valid), 0);
      tick(0, 0, 0, 1);
      check("st_rel_pc4", o_fd_pc4, 32'h4);
      check("st_rel_req", 32'(o_req_valid), 1);
      check("st_rel_addr", o_req_addr, 32'h8);
      tick(0, 0, 0, 1);
      check("st_drain1", o_fd_pc4, 32'h8);
      tick(0, 0, 0, 1);
      check("st_drain2", o_fd_pc4, 32'hC);
      check("st_resume_addr", o_req_addr, 32'hC);

      // Memory back-pressure keeps the request stable
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 0);
         check("bp_valid", 32'(o_req_valid), 1);
         check("bp_addr", o_req_addr, 32'h0);
      end
      tick(0, 0, 0, 1);
      check("bp_accept_addr", o_req_addr, 32'h0);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("bp_fd_pc4", o_fd_pc4, 32'h4);

      // Redirect while waiting for 0x8: the late response is dropped
      do_reset();
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
      mem_lat = 3;
      tick(0, 0, 0, 1);
      check("rw_req8", o_req_addr, 32'h8);
      tick(0, 1, 32'h100, 1);
      check("rw_redir_no_req", 32'(o_req_valid), 0);
      tick(0, 0, 0, 1);
      check("rw_drop_no_req", 32'(o_req_valid), 0);
      check("rw_drop_fd", 32'(o_fd_valid), 0);
      mem_lat = 1;
      tick(0, 0, 0, 1);
      check("rw_late_resp_fd", 32'(o_fd_valid), 0);
      tick(0, 0, 0, 1);
      check("rw_new_req", 32'(o_req_valid), 1);
      check("rw_new_addr", o_req_addr, 32'h100);
      check("rw_new_fd", 32'(o_fd_valid), 0);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("rw_fd_pc4", o_fd_pc4, 32'h104);
      check("rw_fd_instr", o_fd_instr, mem_fn(32'h100));

      // Redirect coinciding with the 0x8 response while stalled
      do_reset();
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
      tick(1, 0, 0, 1);
      check("rr_held_pc4", o_fd_pc4, 32'h8);
      check("rr_req8", o_req_addr, 32'h8);
      tick(1, 1, 32'h203, 1);
      check("rr_redir_no_req", 32'(o_req_valid), 0);
      tick(0, 0, 0, 1);
      check("rr_flush_fd", 32'(o_fd_valid), 0);
      check("rr_flush_pc4", o_fd_pc4, 32'h0);
      check("rr_flush_instr", o_fd_instr, 32'h0);
      check("rr_new_addr", o_req_addr, 32'h200);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("rr_fd_pc4", o_fd_pc4, 32'h204);

      // Reset in the middle of a wait; the stale response must be ignored
      do_reset();
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 1);
      mem_lat = 3;
      tick(1, 0, 0, 1);
      check("mr_req4", o_req_addr, 32'h4);
      check("mr_pre_fd", 32'(fd_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mr_fd_valid", 32'(fd_valid), 0);
      check("mr_fd_pc4", fd_pc4, 32'h0);
      check("mr_fd_instr", fd_instruction, 32'h0);
      check("mr_req_valid", 32'(imem.req_valid), 0);
      tick(0, 0, 0, 0);
      rst_n = 1'b1;
      mem_lat = 1;
      tick(0, 0, 0, 0);
      check("mr_first_req", 32'(o_req_valid), 1);
      check("mr_first_addr", o_req_addr, 32'h0);
      tick(0, 0, 0, 0);
      check("mr_stale_fd", 32'(o_fd_valid), 0);
      tick(0, 0, 0, 1);
      check("mr_after_stale_fd", 32'(o_fd_valid), 0);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("mr_fd_pc4_new", o_fd_pc4, 32'h4);
      check("mr_fd_instr_new", o_fd_instr, mem_fn(32'h0));

      // Randomized run against the program-order model
      do_reset();
      exp_next     = 32'h4;
      prev_rv      = 1'b0;
      prev_hold    = 1'b0;
      prev_fd_hold = 1'b0;
      prev_addr    = '0;
      prev_pc4     = '0;
      prev_instr   = '0;
      consumed     = 0;
      for (int n = 0; n < 3000; n++) begin
         st      = ($urandom_range(0, 9) < 3);
         rv      = ($urandom_range(0, 19) == 0);
         rpc     = $urandom & 32'h0000_FFFF;
         rdy     = ($urandom_range(0, 9) < 7);
         mem_lat = $urandom_range(1, 3);
         tick(st, rv, rpc, rdy);
         if (prev_rv) check("r_flush_fd", 32'(o_fd_valid), 0);
         if (rv) check("r_redir_no_req", 32'(o_req_valid), 0);
         if (o_req_valid) begin
            check("r_align", 32'(o_req_addr[1:0]), 0);
            check("r_one_outstanding", 32'(o_pend), 0);
         end
         if (prev_hold && !rv) begin
            check("r_req_hold", 32'(o_req_valid), 1);
            check("r_req_hold_addr", o_req_addr, prev_addr);
         end
         if (prev_fd_hold) begin
            check("r_fd_hold", 32'(o_fd_valid), 1);
            check("r_fd_hold_pc4", o_fd_pc4, prev_pc4);
            check("r_fd_hold_instr", o_fd_instr, prev_instr);
         end
         if (o_fd_valid && !st && !rv) begin
            check("r_order_pc4", o_fd_pc4, exp_next);
            check("r_instr", o_fd_instr, mem_fn(exp_next - 32'h4));
            exp_next = exp_next + 32'h4;
            consumed++;
         end
         if (rv) exp_next = {rpc[31:2], 2'b00} + 32'h4;
         prev_rv      = rv;
         prev_hold    = o_req_valid & ~rdy & ~rv;
         prev_addr    = o_req_addr;
         prev_fd_hold = o_fd_valid & st & ~rv;
         prev_pc4     = o_fd_pc4;
         prev_instr   = o_fd_instr;
      end
      check("r_progress", 32'(consumed > 200), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that feeds the fetch/decode pipeline register of the 5-stage core.
- Owns the PC and issues word requests to instruction memory over a valid/ready request and valid response interface.
- Buffers returned instructions with their PC+4 in a small prefetch FIFO.
- Honours decode stalls (load-use) and branch/jump redirects, discarding wrong-path data.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, >=2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  word address of request (bits [1:0] always 0).
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  instruction word returned.
- imem_resp_data  in  XLEN  returned instruction.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored, forced 0.
- stall  in  1  decode cannot accept this cycle.
- fd_valid  out  1  fd_instruction/fd_pc4 hold a valid entry.
- fd_instruction  out  XLEN  head-of-FIFO instruction.
- fd_pc4  out  XLEN  head-of-FIFO fetch address + 4.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, state=RUN.
- Reset output values: imem_req_valid=0, fd_valid=0, fd_instruction=0, fd_pc4=0.
- Outstanding limit: at most one request in flight. Issue is allowed only when FIFO count + outstanding < FIFO_DEPTH.
- States:
  - RUN: no request outstanding. imem_req_valid = space_ok & ~redirect_valid; imem_req_addr = pc. On accept (valid&ready), latch req_addr, pc <= pc+4 (wraps mod 2^XLEN), go to WAIT.
  - WAIT: one request outstanding; imem_req_valid=0. On imem_resp_valid, push {resp_data, req_addr+4} and go to RUN.
  - DROP: one wrong-path request outstanding; imem_req_valid=0. On imem_resp_valid, discard the data and go to RUN.
- Redirect (highest priority, any state):
  - FIFO flushed.
  - pc <= redirect_pc.
  - WAIT->DROP, RUN->RUN, DROP->DROP.
  - A response arriving in the same cycle is discarded, and the state returns to RUN (from WAIT or DROP).
  - No request is issued in a redirect cycle.
- Consume: fd_valid & ~stall pops the head at the clock edge. fd_valid = FIFO non-empty. Outputs are registered FIFO head; they hold their values while stalled; entries are 0 when empty.
- Simultaneous push and pop: allowed at any count, including full. Count is unchanged.
- Redirect with stall or pop in the same cycle: flush wins, and fd_valid=0 next cycle.
- Latency: request accepted at cycle N, response at N+k (k>=1), fd_valid at N+k+1. Best case is one instruction every 2 cycles (single outstanding).
- Responses arriving with nothing outstanding (RUN) are ignored. Verification flags these with an assertion.
- Full FIFO: no requests are issued. An unstalled pop frees space, and the request may issue in the same cycle.
- Reset mid-operation: everything returns to reset values immediately. Any response to a pre-reset request is ignored (state RUN).

Decomposition:
- Package fetch_pkg holds:
  - state enum {RUN, WAIT, DROP};
  - XLEN default;
  - PC_STEP=4;
  - NOP instruction constant 32'h0000_0000.
- Sub-module fetch_fifo(clk, rst_n, flush, push, push_data[2*XLEN], pop, head[2*XLEN], empty, full, count). Synchronous flush; head registered; push and pop on the same cycle are legal.
- fetch_unit contains the PC, the FSM and the credit check.

Test Plan:
- Reset, then k=1, ready=1, no stall: requests to 0x0,0x4,0x8 on alternating cycles. fd_valid rises 2 cycles after the first accept with instr0 and fd_pc4=0x4, then 0x8, 0xC in order.
- Hold stall=1 for 10 cycles: FIFO fills to 2, imem_req_valid=0. fd outputs stay at the 0x0 entry. Release stall: entries drain in order and fetching resumes at 0x8.
- imem_req_ready=0 for 3 cycles: imem_req_valid stays 1 with a stable address, and the pc does not advance.
- Redirect to 0x100 while in WAIT for 0x8: the later response is discarded. The next request is to 0x100, and the first fd_pc4 after the flush is 0x104.
- Redirect to 0x200 in the same cycle as the 0x8 response with stall=1: no push, fd_valid=0 next cycle, and the next request is to 0x200.
- Assert rst_n=0 mid-WAIT with a 2-entry FIFO: outputs go to 0 immediately. After release, the first request is RESET_PC. A stale response arriving in RUN is ignored.
